// File: rtl/stone.sv
// stone: rock-paper-scissors judge for a two-player board game.
// Both 2-bit moves are latched on the rising edge of btn_play. The verdict is
// registered onto three one-hot LEDs, which hold until the next play.
// Optional build macro: STONE_SCORE_EN adds saturating 4-bit win counters.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no play since reset, leds dark (000)
// SHOW  | verdict of the most recent play held on leds
module stone #(
    parameter bit LED_ACT_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] player1,
    input  logic [1:0] player2,
    input  logic       btn_play,
`ifdef STONE_SCORE_EN
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
`endif
    output logic [2:0] leds
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    localparam logic [1:0] MOVE_STONE    = 2'b00;
    localparam logic [1:0] MOVE_PAPER    = 2'b01;
    localparam logic [1:0] MOVE_SCISSORS = 2'b10;
    localparam logic [1:0] MOVE_INVALID  = 2'b11;

    localparam logic [2:0] V_NONE = 3'b000;
    localparam logic [2:0] V_P1   = 3'b001;
    localparam logic [2:0] V_P2   = 3'b010;
    localparam logic [2:0] V_DRAW = 3'b100;
    localparam logic [2:0] V_ERR  = 3'b111;

    logic [0:0] state;
    logic       btn_q;
    logic       play;
    logic [2:0] verdict;
    logic [2:0] led_q;
    logic [2:0] led_int;

    assign play = btn_play & ~btn_q;

    // Judge the current switch settings; an invalid move outranks a draw.
    always_comb begin
        verdict = V_ERR;
        if ((player1 == MOVE_INVALID) || (player2 == MOVE_INVALID)) begin
            verdict = V_ERR;
        end else if (player1 == player2) begin
            verdict = V_DRAW;
        end else if (((player1 == MOVE_STONE)    && (player2 == MOVE_SCISSORS)) ||
                     ((player1 == MOVE_SCISSORS) && (player2 == MOVE_PAPER))    ||
                     ((player1 == MOVE_PAPER)    && (player2 == MOVE_STONE))) begin
            verdict = V_P1;
        end else begin
            verdict = V_P2;
        end
    end

    // Delay the button by one clock so a held press is only seen once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_play;
        end
    end

    // FSM and verdict register: every play edge latches a fresh verdict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            led_q <= V_NONE;
        end else if (play) begin
            state <= SHOW;
            led_q <= verdict;
        end
    end

`ifdef STONE_SCORE_EN
    // Win counters saturate at 15; draws and invalid moves score nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_score <= 4'd0;
            p2_score <= 4'd0;
        end else if (play) begin
            if ((verdict == V_P1) && (p1_score != 4'hF)) begin
                p1_score <= p1_score + 4'd1;
            end
            if ((verdict == V_P2) && (p2_score != 4'hF)) begin
                p2_score <= p2_score + 4'd1;
            end
        end
    end
`endif

    // LEDs are dark only in IDLE; polarity flip happens only at the pins.
    assign led_int = (state == SHOW) ? led_q : V_NONE;
    assign leds    = LED_ACT_LOW ? ~led_int : led_int;

endmodule

// File: tb/tb_stone.sv
// tb_stone: scoreboard bench for the stone judge.
module tb_stone;

    localparam bit         LED_ACT_LOW = 1'b0;
    localparam logic [2:0] PIN_XOR     = LED_ACT_LOW ? 3'b111 : 3'b000;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] player1;
    logic [1:0] player2;
    logic       btn_play;
    logic [2:0] leds;
`ifdef STONE_SCORE_EN
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    int         sc1 = 0;
    int         sc2 = 0;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] sb[$];
    logic [2:0] exp;

    stone #(.LED_ACT_LOW(LED_ACT_LOW)) dut (
        .clk      (clk),
        .reset    (reset),
        .player1  (player1),
        .player2  (player2),
        .btn_play (btn_play),
`ifdef STONE_SCORE_EN
        .p1_score (p1_score),
        .p2_score (p2_score),
`endif
        .leds     (leds)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    // Reference judge: cyclic difference of move codes decides the winner.
    function automatic logic [2:0] model(input logic [1:0] a, input logic [1:0] b);
        int d;
        if ((a == 2'b11) || (b == 2'b11)) return 3'b111;
        if (a == b) return 3'b100;
        d = (int'(a) - int'(b) + 3) % 3;
        return (d == 1) ? 3'b001 : 3'b010;
    endfunction

    // One-cycle press from negedge to negedge; expected verdict queued.
    task automatic press(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] v;
        @(negedge clk);
        player1  = a;
        player2  = b;
        btn_play = 1'b1;
        v = model(a, b);
        sb.push_back(v ^ PIN_XOR);
`ifdef STONE_SCORE_EN
        if ((v == 3'b001) && (sc1 < 15)) sc1++;
        if ((v == 3'b010) && (sc2 < 15)) sc2++;
`endif
        @(negedge clk);
        btn_play = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        btn_play = 1'b0;
        player1  = 2'b00;
        player2  = 2'b00;
        repeat (2) @(negedge clk);
        n_checks++;
        if (leds !== PIN_XOR) begin
            n_fail++;
            $display("FAIL reset_leds: leds=%b expected=%b", leds, PIN_XOR);
        end
        reset   = 1'b1;
        player1 = 2'b01;
        player2 = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (leds !== PIN_XOR) begin
                n_fail++;
                $display("FAIL idle_no_press[%0d]: leds=%b expected=%b", k, leds, PIN_XOR);
            end
        end
`ifdef STONE_SCORE_EN
        n_checks++;
        if ((p1_score !== 4'd0) || (p2_score !== 4'd0)) begin
            n_fail++;
            $display("FAIL reset_scores: p1=%0d p2=%0d expected 0 0", p1_score, p2_score);
        end
`endif
    endtask

    task automatic test_draw();
        press(2'b00, 2'b00);
        exp = sb.pop_front();
        n_checks++;
        if (leds !== exp) begin
            n_fail++;
            $display("FAIL draw: leds=%b expected=%b", leds, exp);
        end
    endtask

    task automatic test_patterns();
        press(2'b00, 2'b10);
        press(2'b00, 2'b01);
        press(2'b10, 2'b00);
        sb.delete();
        for (int i = 0; i < 16; i++) begin
            press(i[3:2], i[1:0]);
            exp = sb.pop_front();
            n_checks++;
            if (leds !== exp) begin
                n_fail++;
                $display("FAIL pattern p1=%b p2=%b: leds=%b expected=%b",
                         i[3:2], i[1:0], leds, exp);
            end
        end
    endtask

    task automatic test_no_press();
        press(2'b10, 2'b10);
        exp = sb.pop_front();
        n_checks++;
        if (leds !== exp) begin
            n_fail++;
            $display("FAIL scissors_draw: leds=%b expected=%b", leds, exp);
        end
        player1 = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (leds !== exp) begin
                n_fail++;
                $display("FAIL move_change_no_press[%0d]: leds=%b expected=%b", k, leds, exp);
            end
        end
    endtask

    task automatic test_hold();
        logic [2:0] v;
        @(negedge clk);
        player1  = 2'b01;
        player2  = 2'b00;
        btn_play = 1'b1;
        v = model(2'b01, 2'b00);
        sb.push_back(v ^ PIN_XOR);
`ifdef STONE_SCORE_EN
        if (sc1 < 15) sc1++;
`endif
        @(negedge clk);
        exp = sb.pop_front();
        n_checks++;
        if (leds !== exp) begin
            n_fail++;
            $display("FAIL hold_first: leds=%b expected=%b", leds, exp);
        end
        player1 = 2'b01;
        player2 = 2'b10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (leds !== exp) begin
                n_fail++;
                $display("FAIL hold_reevaluated[%0d]: leds=%b expected=%b", k, leds, exp);
            end
        end
        btn_play = 1'b0;
        @(negedge clk);
`ifdef STONE_SCORE_EN
        n_checks++;
        if ((p1_score !== sc1[3:0]) || (p2_score !== sc2[3:0])) begin
            n_fail++;
            $display("FAIL hold_score: p1=%0d p2=%0d expected %0d %0d",
                     p1_score, p2_score, sc1, sc2);
        end
`endif
    endtask

    task automatic test_back_to_back();
        press(2'b00, 2'b01);
        exp = sb.pop_front();
        n_checks++;
        if (leds !== exp) begin
            n_fail++;
            $display("FAIL b2b_first: leds=%b expected=%b", leds, exp);
        end
        press(2'b01, 2'b01);
        exp = sb.pop_front();
        n_checks++;
        if (leds !== exp) begin
            n_fail++;
            $display("FAIL b2b_second: leds=%b expected=%b", leds, exp);
        end
    endtask

`ifdef STONE_SCORE_EN
    task automatic test_saturation();
        for (int k = 0; k < 17; k++) begin
            press(2'b00, 2'b10);
            exp = sb.pop_front();
        end
        press(2'b10, 2'b00);
        exp = sb.pop_front();
        n_checks++;
        if ((p1_score !== sc1[3:0]) || (p2_score !== sc2[3:0]) || (sc1 != 15)) begin
            n_fail++;
            $display("FAIL score_saturation: p1=%0d p2=%0d expected %0d %0d",
                     p1_score, p2_score, sc1, sc2);
        end
    endtask
`endif

    task automatic test_reset_mid();
        press(2'b11, 2'b00);
        exp = sb.pop_front();
        n_checks++;
        if (leds !== exp) begin
            n_fail++;
            $display("FAIL invalid_move: leds=%b expected=%b", leds, exp);
        end
        @(negedge clk);
        player1  = 2'b00;
        player2  = 2'b10;
        btn_play = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (leds !== PIN_XOR) begin
            n_fail++;
            $display("FAIL reset_async: leds=%b expected=%b", leds, PIN_XOR);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (leds !== PIN_XOR) begin
            n_fail++;
            $display("FAIL reset_held: leds=%b expected=%b", leds, PIN_XOR);
        end
`ifdef STONE_SCORE_EN
        sc1 = 0;
        sc2 = 0;
        n_checks++;
        if ((p1_score !== 4'd0) || (p2_score !== 4'd0)) begin
            n_fail++;
            $display("FAIL reset_mid_scores: p1=%0d p2=%0d expected 0 0", p1_score, p2_score);
        end
`endif
        btn_play = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (leds !== PIN_XOR) begin
            n_fail++;
            $display("FAIL after_reset_idle: leds=%b expected=%b", leds, PIN_XOR);
        end
        press(2'b01, 2'b00);
        exp = sb.pop_front();
        n_checks++;
        if (leds !== exp) begin
            n_fail++;
            $display("FAIL after_reset_play: leds=%b expected=%b", leds, exp);
        end
    endtask

    initial begin
        test_reset();
        test_draw();
        test_patterns();
        test_no_press();
        test_hold();
        test_back_to_back();
`ifdef STONE_SCORE_EN
        test_saturation();
`endif
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: entries=%0d expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
